// File: rtl/sc_mover_pkg.sv
// Shared types and helpers for the one-hot position mover.
// Build option SC_ONEHOTMOVER_WRAP_EN is consumed by sc_onehot_mover.
package sc_mover_pkg;

    localparam logic [1:0] DIR_HI = 2'b01;
    localparam logic [1:0] DIR_LO = 2'b10;

    // Widest position register the helper functions can check.
    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_COOLDOWN = 1'b1
    } moverState_t;

    function automatic logic [MAX_WIDTH-1:0] legalMask(input int lo, input int hi);
        logic [MAX_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i >= lo && i <= hi) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    function automatic logic onehotInRange(input logic [MAX_WIDTH-1:0] vec,
                                           input logic [MAX_WIDTH-1:0] mask);
        return (vec != '0) && ((vec & (vec - MAX_WIDTH'(1))) == '0) && ((vec & ~mask) == '0);
    endfunction

endpackage

// File: rtl/sc_mover_cooldown.sv
// Cooldown down-counter: loads COUNT-1 on start, counts to zero, busy while nonzero.
// A load strobe on the mover side aborts any count in progress.
module sc_mover_cooldown #(
    parameter int COUNT = 2
) (
    input  logic SC_MoverCOOLDOWN_CLOCK_50,
    input  logic SC_MoverCOOLDOWN_RESET_InHigh,
    input  logic SC_MoverCOOLDOWN_start,
    input  logic SC_MoverCOOLDOWN_abort,
    output logic SC_MoverCOOLDOWN_busy
);

    localparam int CntW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'((COUNT > 0) ? COUNT - 1 : 0);

    logic [CntW-1:0] countQ;

    always_ff @(posedge SC_MoverCOOLDOWN_CLOCK_50) begin
        if (SC_MoverCOOLDOWN_RESET_InHigh || SC_MoverCOOLDOWN_abort) begin
            countQ <= '0;
        end else if (SC_MoverCOOLDOWN_start) begin
            countQ <= LoadVal;
        end else if (countQ != '0) begin
            countQ <= countQ - CntW'(1);
        end
    end

    assign SC_MoverCOOLDOWN_busy = (countQ != '0);

endmodule

// File: rtl/sc_onehot_mover.sv
// One-hot position mover with clamp (or wrap when SC_ONEHOTMOVER_WRAP_EN is defined),
// validated load and a cooldown rate limiter.
//
//   state        | meaning
//   -------------+---------------------------------------------
//   ST_IDLE      | ready high, next valid move request accepted
//   ST_COOLDOWN  | ready low, waiting for the cooldown counter
module sc_onehot_mover
    import sc_mover_pkg::*;
#(
    parameter int DATAWIDTH       = 8,
    parameter int LIMIT_LO        = 4,
    parameter int LIMIT_HI        = 7,
    parameter int RESET_POS       = 4,
    parameter int COOLDOWN_CYCLES = 2
) (
    input  logic                 SC_OnehotMOVER_CLOCK_50,
    input  logic                 SC_OnehotMOVER_RESET_InHigh,
    input  logic                 SC_OnehotMOVER_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_OnehotMOVER_data_InBUS,
    input  logic                 SC_OnehotMOVER_req_valid_In,
    output logic                 SC_OnehotMOVER_req_ready_Out,
    input  logic [1:0]           SC_OnehotMOVER_dir_In,
    output logic [DATAWIDTH-1:0] SC_OnehotMOVER_data_OutBUS,
    output logic                 SC_OnehotMOVER_atHi_Out,
    output logic                 SC_OnehotMOVER_atLo_Out,
    output logic                 SC_OnehotMOVER_moved_Out,
    output logic                 SC_OnehotMOVER_blocked_Out,
    output logic                 SC_OnehotMOVER_loaderr_Out
);

    localparam logic [DATAWIDTH-1:0] ResetVal = DATAWIDTH'(1) << RESET_POS;
    localparam logic [DATAWIDTH-1:0] LoPos    = DATAWIDTH'(1) << LIMIT_LO;
    localparam logic [DATAWIDTH-1:0] HiPos    = DATAWIDTH'(1) << LIMIT_HI;
    localparam logic [MAX_WIDTH-1:0] LegalMask = legalMask(LIMIT_LO, LIMIT_HI);

    moverState_t          stateQ, stateD;
    logic [DATAWIDTH-1:0] posQ, posD;
    logic                 movedQ, movedD;
    logic                 blockedQ, blockedD;
    logic                 loaderrQ, loaderrD;
    logic                 loadActive, loadOk, dirIsMove, atHi, atLo;
    logic                 coolStart, coolBusy, ready;

    assign loadActive = !SC_OnehotMOVER_load_InLow;
    assign loadOk     = onehotInRange(MAX_WIDTH'(SC_OnehotMOVER_data_InBUS), LegalMask);
    assign dirIsMove  = (SC_OnehotMOVER_dir_In == DIR_HI) || (SC_OnehotMOVER_dir_In == DIR_LO);
    assign atHi       = (posQ == HiPos);
    assign atLo       = (posQ == LoPos);

    sc_mover_cooldown #(
        .COUNT(COOLDOWN_CYCLES)
    ) uCooldown (
        .SC_MoverCOOLDOWN_CLOCK_50    (SC_OnehotMOVER_CLOCK_50),
        .SC_MoverCOOLDOWN_RESET_InHigh(SC_OnehotMOVER_RESET_InHigh),
        .SC_MoverCOOLDOWN_start       (coolStart),
        .SC_MoverCOOLDOWN_abort       (loadActive),
        .SC_MoverCOOLDOWN_busy        (coolBusy)
    );

    always_ff @(posedge SC_OnehotMOVER_CLOCK_50) begin
        if (SC_OnehotMOVER_RESET_InHigh) begin
            stateQ   <= ST_IDLE;
            posQ     <= ResetVal;
            movedQ   <= 1'b0;
            blockedQ <= 1'b0;
            loaderrQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            posQ     <= posD;
            movedQ   <= movedD;
            blockedQ <= blockedD;
            loaderrQ <= loaderrD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        posD      = posQ;
        movedD    = 1'b0;
        blockedD  = 1'b0;
        loaderrD  = 1'b0;
        coolStart = 1'b0;
        ready     = (stateQ == ST_IDLE);

        if (loadActive) begin
            // Load wins over any request and always drops back to IDLE.
            stateD = ST_IDLE;
            if (loadOk) begin
                posD = SC_OnehotMOVER_data_InBUS;
            end else begin
                loaderrD = 1'b1;
            end
        end else begin
            unique case (stateQ)
                ST_IDLE: begin
                    if (SC_OnehotMOVER_req_valid_In && dirIsMove) begin
                        if (COOLDOWN_CYCLES > 0) begin
                            stateD    = ST_COOLDOWN;
                            coolStart = 1'b1;
                        end
                        if (SC_OnehotMOVER_dir_In == DIR_HI) begin
                            if (atHi) begin
`ifdef SC_ONEHOTMOVER_WRAP_EN
                                posD   = LoPos;
                                movedD = 1'b1;
`else
                                blockedD = 1'b1;
`endif
                            end else begin
                                posD   = posQ << 1;
                                movedD = 1'b1;
                            end
                        end else begin
                            if (atLo) begin
`ifdef SC_ONEHOTMOVER_WRAP_EN
                                posD   = HiPos;
                                movedD = 1'b1;
`else
                                blockedD = 1'b1;
`endif
                            end else begin
                                posD   = posQ >> 1;
                                movedD = 1'b1;
                            end
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (!coolBusy) begin
                        stateD = ST_IDLE;
                    end
                end
                default: stateD = ST_IDLE;
            endcase
        end
    end

    assign SC_OnehotMOVER_req_ready_Out = ready;
    assign SC_OnehotMOVER_data_OutBUS   = posQ;
    assign SC_OnehotMOVER_atHi_Out      = atHi;
    assign SC_OnehotMOVER_atLo_Out      = atLo;
    assign SC_OnehotMOVER_moved_Out     = movedQ;
    assign SC_OnehotMOVER_blocked_Out   = blockedQ;
    assign SC_OnehotMOVER_loaderr_Out   = loaderrQ;

endmodule

// File: tb/tb_sc_onehot_mover.sv
// Directed bench for sc_onehot_mover: default instance plus a no-cooldown instance.
module tb_sc_onehot_mover;

`ifdef SC_ONEHOTMOVER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       loadN, valid;
    logic [7:0] dataIn;
    logic [1:0] dir;
    logic [7:0] dataOut;
    logic       ready, atHi, atLo, moved, blocked, loaderr;

    logic       loadNB, validB;
    logic [7:0] dataInB;
    logic [1:0] dirB;
    logic [7:0] dataOutB;
    logic       readyB, atHiB, atLoB, movedB, blockedB, loaderrB;

    int testsRun = 0;
    int testsFailed = 0;

    always #10 clk = ~clk;

    sc_onehot_mover dutA (
        .SC_OnehotMOVER_CLOCK_50     (clk),
        .SC_OnehotMOVER_RESET_InHigh (rst),
        .SC_OnehotMOVER_load_InLow   (loadN),
        .SC_OnehotMOVER_data_InBUS   (dataIn),
        .SC_OnehotMOVER_req_valid_In (valid),
        .SC_OnehotMOVER_req_ready_Out(ready),
        .SC_OnehotMOVER_dir_In       (dir),
        .SC_OnehotMOVER_data_OutBUS  (dataOut),
        .SC_OnehotMOVER_atHi_Out     (atHi),
        .SC_OnehotMOVER_atLo_Out     (atLo),
        .SC_OnehotMOVER_moved_Out    (moved),
        .SC_OnehotMOVER_blocked_Out  (blocked),
        .SC_OnehotMOVER_loaderr_Out  (loaderr)
    );

    sc_onehot_mover #(.COOLDOWN_CYCLES(0)) dutB (
        .SC_OnehotMOVER_CLOCK_50     (clk),
        .SC_OnehotMOVER_RESET_InHigh (rst),
        .SC_OnehotMOVER_load_InLow   (loadNB),
        .SC_OnehotMOVER_data_InBUS   (dataInB),
        .SC_OnehotMOVER_req_valid_In (validB),
        .SC_OnehotMOVER_req_ready_Out(readyB),
        .SC_OnehotMOVER_dir_In       (dirB),
        .SC_OnehotMOVER_data_OutBUS  (dataOutB),
        .SC_OnehotMOVER_atHi_Out     (atHiB),
        .SC_OnehotMOVER_atLo_Out     (atLoB),
        .SC_OnehotMOVER_moved_Out    (movedB),
        .SC_OnehotMOVER_blocked_Out  (blockedB),
        .SC_OnehotMOVER_loaderr_Out  (loaderrB)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; loadN = 1'b1; valid = 1'b0; dir = 2'b00; dataIn = 8'h00;
        loadNB = 1'b1; validB = 1'b0; dirB = 2'b00; dataInB = 8'h00;
        step(); step();
        rst = 1'b0;
        check("reset_pos", dataOut, 8'h10);
        check("reset_ready", ready, 1'b1);
        check("reset_atLo", atLo, 1'b1);
        check("reset_atHi", atHi, 1'b0);
        check("reset_pulses", {moved, blocked, loaderr}, 3'b000);

        // valid held toward HI: second move lands on the 3rd edge after the first
        valid = 1'b1; dir = 2'b01;
        step();
        check("mv1_pos", dataOut, 8'h20);
        check("mv1_moved", moved, 1'b1);
        check("mv1_ready", ready, 1'b0);
        step();
        check("cd1_ready", ready, 1'b0);
        check("cd1_moved", moved, 1'b0);
        check("cd1_pos", dataOut, 8'h20);
        step();
        check("cd2_ready", ready, 1'b1);
        check("cd2_pos", dataOut, 8'h20);
        step();
        check("mv2_pos", dataOut, 8'h40);
        check("mv2_moved", moved, 1'b1);
        valid = 1'b0;
        step(); step();
        check("mv2_ready_back", ready, 1'b1);

        valid = 1'b1; dir = 2'b01;
        step();
        check("mv3_pos", dataOut, 8'h80);
        check("mv3_atHi", {atHi, atLo}, 2'b10);
        valid = 1'b0;
        step(); step();

        // move past HI: clamp, or wrap to LO
        valid = 1'b1; dir = 2'b01;
        step();
        check("hi_edge_pos", dataOut, WRAP ? 8'h10 : 8'h80);
        check("hi_edge_blocked", blocked, WRAP ? 1'b0 : 1'b1);
        check("hi_edge_moved", moved, WRAP ? 1'b1 : 1'b0);
        check("hi_edge_ready", ready, 1'b0);
        valid = 1'b0;
        step();
        check("hi_edge_pulse_end", {moved, blocked}, 2'b00);

        // load during cooldown together with a request
        loadN = 1'b0; dataIn = 8'h40; valid = 1'b1; dir = 2'b10;
        step();
        check("load_pos", dataOut, 8'h40);
        check("load_no_move", {moved, blocked, loaderr}, 3'b000);
        check("load_ready", ready, 1'b1);
        valid = 1'b0;
        dataIn = 8'h03;
        step();
        check("load03_pos", dataOut, 8'h40);
        check("load03_err", loaderr, 1'b1);
        dataIn = 8'h02;
        step();
        check("load02_pos", dataOut, 8'h40);
        check("load02_err", loaderr, 1'b1);
        loadN = 1'b1;
        step();
        check("loaderr_end", loaderr, 1'b0);
        check("loaderr_ready", ready, 1'b1);

        // reset mid-cooldown
        valid = 1'b1; dir = 2'b10;
        step();
        check("mv4_pos", dataOut, 8'h20);
        valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_cd_pos", dataOut, 8'h10);
        check("rst_cd_ready", ready, 1'b1);
        check("rst_cd_moved", moved, 1'b0);
        step();
        check("rst_cd_ready2", ready, 1'b1);
        valid = 1'b1; dir = 2'b01;
        step();
        check("mv5_pos", dataOut, 8'h20);
        valid = 1'b0;
        step();
        check("mv5_cd_ready", ready, 1'b0);
        step();
        check("mv5_ready_back", ready, 1'b1);

        valid = 1'b1; dir = 2'b10;
        step();
        check("mv6_pos", dataOut, 8'h10);
        valid = 1'b0;
        step(); step();

        // move past LO
        valid = 1'b1; dir = 2'b10;
        step();
        check("lo_edge_pos", dataOut, WRAP ? 8'h80 : 8'h10);
        check("lo_edge_blocked", blocked, WRAP ? 1'b0 : 1'b1);
        check("lo_edge_moved", moved, WRAP ? 1'b1 : 1'b0);
        valid = 1'b0;
        step(); step();

        // no-op directions are consumed without effect
        valid = 1'b1; dir = 2'b11;
        step();
        check("noop11_pos", dataOut, WRAP ? 8'h80 : 8'h10);
        check("noop11_ready", ready, 1'b1);
        check("noop11_pulses", {moved, blocked}, 2'b00);
        dir = 2'b00;
        step();
        check("noop00_pos", dataOut, WRAP ? 8'h80 : 8'h10);
        check("noop00_ready", ready, 1'b1);
        valid = 1'b0;

        // zero-cooldown instance
        loadNB = 1'b0; dataInB = 8'h80;
        step();
        check("b_load_pos", dataOutB, 8'h80);
        loadNB = 1'b1; validB = 1'b1; dirB = 2'b10;
        step();
        check("b_mv1_pos", dataOutB, 8'h40);
        check("b_mv1_moved", movedB, 1'b1);
        check("b_mv1_ready", readyB, 1'b1);
        step();
        check("b_mv2_pos", dataOutB, 8'h20);
        step();
        check("b_mv3_pos", dataOutB, 8'h10);
        check("b_mv3_atLo", atLoB, 1'b1);
        step();
        check("b_edge1_pos", dataOutB, WRAP ? 8'h80 : 8'h10);
        check("b_edge1_blocked", blockedB, WRAP ? 1'b0 : 1'b1);
        step();
        check("b_edge2_pos", dataOutB, WRAP ? 8'h40 : 8'h10);
        check("b_edge2_blocked", blockedB, WRAP ? 1'b0 : 1'b1);
        check("b_edge2_ready", readyB, 1'b1);
        validB = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
